// File: rtl/warmboot_sequencer.sv
// Warm-boot sequencer: debounced button press selects a boot slot and pulses BOOT after a delay.
// Define WBSEQ_CONFIRM_EN to require a second press within a confirmation window (ARM state).

module warmboot_sequencer #(
  parameter int SLOT_W          = 4,
  parameter int NUM_SLOTS       = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DELAY_CYCLES    = 100000,
  parameter int CONFIRM_CYCLES  = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SLOT_W-1:0] slot_sel,
  input  logic              boot_btn,
  input  logic              abort,
  output logic [SLOT_W-1:0] wb_slot,
  output logic              wb_boot,
  output logic              busy,
  output logic              err,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    FIRE  = 2'd3
  } state_t;

  localparam int MAX_CYCLES = (DELAY_CYCLES > CONFIRM_CYCLES) ? DELAY_CYCLES : CONFIRM_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
  localparam int DB_W       = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);
`ifdef WBSEQ_CONFIRM_EN
  localparam logic [CNT_W-1:0] CONFIRM_LOAD = CNT_W'(CONFIRM_CYCLES - 1);
`endif

  // Two-flop synchronisers for the raw asynchronous inputs.
  logic [1:0] btn_sync;
  logic [1:0] abort_sync;
  logic       btn_s;
  logic       abort_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync   <= '0;
      abort_sync <= '0;
    end else begin
      btn_sync   <= {btn_sync[0], boot_btn};
      abort_sync <= {abort_sync[0], abort};
    end
  end

  assign btn_s   = btn_sync[1];
  assign abort_s = abort_sync[1];

  // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  logic            db_level;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (btn_s == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= btn_s;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // The FSM commits on the same edge that raises the debounced level, so busy rises with
  // the press and wb_boot follows exactly DELAY_CYCLES cycles later.
  assign press = btn_s && !db_level && (db_cnt == DB_LAST);

  logic slot_invalid;
  assign slot_invalid = (32'(slot_sel) >= NUM_SLOTS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               err_q, err_d;
  logic               boot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      err_q   <= 1'b0;
      boot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      err_q   <= err_d;
      boot_q  <= (state_d == FIRE);
    end
  end

  always_comb begin
    // NOTE: hold-current defaults first, so no path through the case can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (press) begin
          if (slot_invalid) begin
            err_d = 1'b1;
          end else begin
            slot_d = slot_sel;
            err_d  = 1'b0;
`ifdef WBSEQ_CONFIRM_EN
            state_d = ARM;
            cnt_d   = CONFIRM_LOAD;
`else
            state_d = COUNT;
            cnt_d   = DELAY_LOAD;
`endif
          end
        end
      end

`ifdef WBSEQ_CONFIRM_EN
      ARM: begin
        if (abort_s) begin
          state_d = IDLE;
        end else if (press) begin
          state_d = COUNT;
          cnt_d   = DELAY_LOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      COUNT: begin
        // Abort wins even when the counter has just expired.
        if (abort_s) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = FIRE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      FIRE: begin
        state_d = FIRE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state   = state_q;
  assign busy    = (state_q != IDLE);
  assign wb_boot = boot_q;
  assign wb_slot = slot_q;
  assign err     = err_q;

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Scoreboard bench for warmboot_sequencer: a behavioural model predicts every output change
// and its cycle; a negedge monitor pops and compares whenever the outputs change.

module tb_warmboot_sequencer;

  localparam int SW  = 4;
  localparam int NS  = 4;
  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int CNF = 20;
`ifdef WBSEQ_CONFIRM_EN
  localparam bit CONFIRM = 1'b1;
`else
  localparam bit CONFIRM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] slot_sel;
  logic          boot_btn;
  logic          abort;
  logic [SW-1:0] wb_slot;
  logic          wb_boot;
  logic          busy;
  logic          err;
  logic [1:0]    state;

  warmboot_sequencer #(
    .SLOT_W          (SW),
    .NUM_SLOTS       (NS),
    .DEBOUNCE_CYCLES (DEB),
    .DELAY_CYCLES    (DLY),
    .CONFIRM_CYCLES  (CNF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .slot_sel (slot_sel),
    .boot_btn (boot_btn),
    .abort    (abort),
    .wb_slot  (wb_slot),
    .wb_boot  (wb_boot),
    .busy     (busy),
    .err      (err),
    .state    (state)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [1:0]  st;
    logic        err;
    logic [3:0]  slot;
    logic        boot;
  } ev_t;

  ev_t exp_q[$];

  // Model view of the outputs after the last predicted change.
  logic [1:0] m_st   = 2'd0;
  logic       m_err  = 1'b0;
  logic [3:0] m_slot = 4'd0;
  logic       m_boot = 1'b0;

  function automatic void push_ev(int c, logic [1:0] st, logic e, logic [3:0] s, logic b);
    if (st !== m_st || e !== m_err || s !== m_slot || b !== m_boot) begin
      exp_q.push_back('{cyc: c, st: st, err: e, slot: s, boot: b});
      m_st   = st;
      m_err  = e;
      m_slot = s;
      m_boot = b;
    end
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every observed output change must match the next predicted change, cycle included.
  logic [8:0] prev_snap = 9'd0;
  logic [8:0] snap;
  logic [8:0] want_snap;
  ev_t        ev;

  always @(negedge clk) begin
    snap = {busy, state, err, wb_slot, wb_boot};
    if (snap !== prev_snap) begin
      prev_snap = snap;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cycle %0d got state=%0d err=%0b slot=%0d boot=%0b busy=%0b, expected no change",
                 cyc, state, err, wb_slot, wb_boot, busy);
      end else begin
        ev = exp_q.pop_front();
        want_snap = {ev.st != 2'd0, ev.st, ev.err, ev.slot, ev.boot};
        if (snap !== want_snap || cyc != ev.cyc) begin
          errors++;
          $display("FAIL output_event: got cycle %0d state=%0d err=%0b slot=%0d boot=%0b busy=%0b, expected cycle %0d state=%0d err=%0b slot=%0d boot=%0b",
                   cyc, state, err, wb_slot, wb_boot, busy, ev.cyc, ev.st, ev.err, ev.slot, ev.boot);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wb_boot"}, 32'(wb_boot), 32'd0);
    check({tag, "_state"},   32'(state),   32'd0);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_err"},     32'(err),     32'd0);
    check({tag, "_wb_slot"}, 32'(wb_slot), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop before the next clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    push_ev(cyc, 2'd0, 1'b0, 4'd0, 1'b0);
    boot_btn = 1'b0;
    abort    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One button episode. A press is taken DEB+2 cycles after the button rises (two sync
  // flops, then DEB stable samples) provided it stays up DEB cycles. abort_off < 0 means no
  // abort; otherwise a one-cycle abort is raised abort_off cycles after the press and takes
  // effect three cycles later.
  task automatic run_episode(input int slot, input int hold, input int abort_off);
    int n, t_p, a, last_ev, end_c;
    bit pressed, valid, fired;
    n       = cyc;
    t_p     = n + 2 + DEB;
    pressed = (hold >= DEB);
    valid   = pressed && (slot < NS);
    a       = (abort_off >= 0) ? t_p + abort_off : -100;
    fired   = 1'b0;
    last_ev = n;
    slot_sel = 4'(slot);
    boot_btn = 1'b1;

    if (pressed && !valid)
      push_ev(t_p, 2'd0, 1'b1, m_slot, 1'b0);
    if (valid) begin
      push_ev(t_p, CONFIRM ? 2'd1 : 2'd2, 1'b0, 4'(slot), 1'b0);
      if (abort_off >= 0) begin
        last_ev = a + 3;
        push_ev(last_ev, 2'd0, 1'b0, 4'(slot), 1'b0);
      end else if (!CONFIRM) begin
        last_ev = t_p + DLY;
        push_ev(last_ev, 2'd3, 1'b0, 4'(slot), 1'b1);
        fired = 1'b1;
      end else begin
        last_ev = t_p + CNF;
        push_ev(last_ev, 2'd0, 1'b0, 4'(slot), 1'b0);
      end
    end

    end_c = imax(imax(n + hold + DEB + 4, last_ev + 3), a + 5);
    while (cyc < end_c) begin
      tick();
      boot_btn = (cyc < n + hold);
      abort    = (cyc == a);
      if (cyc >= t_p) slot_sel = 4'($urandom);
    end
    if (fired) do_reset();
  endtask

`ifdef WBSEQ_CONFIRM_EN
  // Press, release, press again inside the window: ARM -> COUNT -> FIRE with the first slot.
  task automatic confirm_double(input int slot);
    int n, t_p, n2, t_p2, hold1, end_c;
    n     = cyc;
    hold1 = DEB + 1;
    t_p   = n + 2 + DEB;
    n2    = n + hold1 + DEB + 3;
    t_p2  = n2 + 2 + DEB;
    slot_sel = 4'(slot);
    boot_btn = 1'b1;
    push_ev(t_p,        2'd1, 1'b0, 4'(slot), 1'b0);
    push_ev(t_p2,       2'd2, 1'b0, 4'(slot), 1'b0);
    push_ev(t_p2 + DLY, 2'd3, 1'b0, 4'(slot), 1'b1);
    end_c = t_p2 + DLY + 3;
    while (cyc < end_c) begin
      tick();
      boot_btn = (cyc < n + hold1) || (cyc >= n2 && cyc < n2 + hold1);
      if (cyc >= t_p) slot_sel = 4'($urandom);
    end
    do_reset();
  endtask
`endif

  initial begin
    rst_n    = 1'b1;
    slot_sel = '0;
    boot_btn = 1'b0;
    abort    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("initial_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_episode(2, 10, -1);          // clean press on slot 2
    run_episode(2, 1, -1);           // glitches shorter than the debounce window
    run_episode(2, 2, -1);
    run_episode(2, 3, -1);
    run_episode(5, DEB + 2, -1);     // out-of-range slot sets err
    run_episode(1, DEB + 2, -1);     // valid slot clears err
    run_episode(3, DEB + 1, 2);      // abort five cycles into the count
    run_episode(0, DEB + 1, DLY - 3);// abort lands exactly on counter zero
`ifdef WBSEQ_CONFIRM_EN
    confirm_double(2);
`endif

    for (int i = 0; i < 40; i++) begin
      int slot, hold, aoff;
      slot = int'($urandom_range(0, 7));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEB - 1))
                                         : int'($urandom_range(DEB, DEB + 6));
      case ($urandom_range(0, 3))
        0:       aoff = int'($urandom_range(0, DLY - 3));
        1:       aoff = DLY - 3;
        default: aoff = -1;
      endcase
      run_episode(slot, hold, aoff);
    end

    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
